wheel_encoder_speed_meter: RTL

- Measures actual wheel speed and direction from two quadrature encoders, one per drive wheel.
- Reports results in the same format the DC motor driver consumes: 8-bit speed per wheel and 4-bit direction.
- Closed-loop control and telemetry logic compare this measured command against the requested one.
- Sits between the encoder input pins and the speed-control and telemetry logic.

---
 rtl/wheel_encoder_speed_meter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wheel_encoder_speed_meter.sv
// Dual quadrature encoder speed meter.
// Each wheel: 2-flop synchronizer, previous-state register, x4 Gray decode into
// a saturating signed 16-bit accumulator. A shared gate counter closes a
// window every GATE_CYCLES clocks and latches |acc| (clamped to 255) and sign.
module wheel_encoder_speed_meter #(
  parameter int GATE_CYCLES  = 1000000,
  parameter bit INVERT_RIGHT = 1'b0
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       enc_left_a,
  input  logic       enc_left_b,
  input  logic       enc_right_a,
  input  logic       enc_right_b,
  input  logic       clr_err,
  output logic [7:0] out_left_speed,
  output logic [7:0] out_right_speed,
  output logic [3:0] out_direction,
  output logic       speed_valid,
  output logic [1:0] quad_error
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  logic [GW-1:0]   gate_q, gate_d;
  logic [1:0]      prime_cnt_q, prime_cnt_d;
  logic            vld_q, vld_d;
  logic            primed, terminal;
  logic [1:0]      enc_a, enc_b;
  logic [1:0][7:0] spd;
  logic [1:0][1:0] dir;
  logic [1:0]      err;

  assign enc_a = {enc_right_a, enc_left_a};
  assign enc_b = {enc_right_b, enc_left_b};

  // Window timing and post-reset priming shared by both wheels.
  always_comb begin
    primed      = (prime_cnt_q == 2'd3);
    terminal    = (gate_q == GATE_LAST);
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 2'd1;
    gate_d      = terminal ? '0 : gate_q + 1'b1;
    vld_d       = terminal;
  end

  // Shared state registers.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      gate_q      <= '0;
      prime_cnt_q <= '0;
      vld_q       <= 1'b0;
    end else begin
      gate_q      <= gate_d;
      prime_cnt_q <= prime_cnt_d;
      vld_q       <= vld_d;
    end
  end

  genvar w;
  generate
    for (w = 0; w < 2; w++) begin : g_wheel
      localparam bit NEG = (w == 1) && INVERT_RIGHT;
      logic [1:0]  s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
      logic [15:0] acc_q, acc_d;
      logic [7:0]  spd_q, spd_d;
      logic [1:0]  dir_q, dir_d;
      logic        err_q, err_d;
      logic [1:0]  inc;
      logic        bad;
      logic [16:0] sum, mag;

      // Sync, x4 decode, saturating accumulate, and window latch for one wheel.
      always_comb begin
        s1_d   = {enc_a[w], enc_b[w]};
        s2_d   = s1_q;
        prev_d = s2_q;
        inc    = 2'b00;
        bad    = 1'b0;
        // Decode stays silent until the pipeline holds post-reset pin values.
        if (primed) begin
          case ({prev_q, s2_q})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: inc = 2'b01;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: inc = 2'b11;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: bad = 1'b1;
            default: ;
          endcase
        end
        if (NEG) inc = 2'b00 - inc;
        sum = {acc_q[15], acc_q} + {{15{inc[1]}}, inc};
        // -32768 gives 32768 here, which clamps to 255 like any large value.
        mag = acc_q[15] ? 17'd0 - {1'b1, acc_q} : {1'b0, acc_q};
        spd_d = spd_q;
        dir_d = dir_q;
        if (terminal) begin
          // Restart with this cycle's increment so a terminal-cycle edge is kept.
          acc_d = {{14{inc[1]}}, inc};
          spd_d = (mag > 17'd255) ? 8'd255 : mag[7:0];
          if (acc_q == 16'd0)  dir_d = 2'b00;
          else if (acc_q[15])  dir_d = 2'b01;
          else                 dir_d = 2'b10;
        end else if (sum[16:15] == 2'b01) begin
          acc_d = 16'h7fff;
        end else if (sum[16:15] == 2'b10) begin
          acc_d = 16'h8000;
        end else begin
          acc_d = sum[15:0];
        end
        // A new error beats a simultaneous clear.
        err_d = (err_q & ~clr_err) | bad;
      end

      // Per-wheel registers.
      always_ff @(posedge clk) begin
        if (reset_p) begin
          s1_q   <= '0;
          s2_q   <= '0;
          prev_q <= '0;
          acc_q  <= '0;
          spd_q  <= '0;
          dir_q  <= '0;
          err_q  <= 1'b0;
        end else begin
          s1_q   <= s1_d;
          s2_q   <= s2_d;
          prev_q <= prev_d;
          acc_q  <= acc_d;
          spd_q  <= spd_d;
          dir_q  <= dir_d;
          err_q  <= err_d;
        end
      end

      assign spd[w] = spd_q;
      assign dir[w] = dir_q;
      assign err[w] = err_q;
    end
  endgenerate

  assign out_left_speed  = spd[0];
  assign out_right_speed = spd[1];
  assign out_direction   = {dir[1], dir[0]};
  assign speed_valid     = vld_q;
  assign quad_error      = err;

endmodule
